ro_puf_sequencer: RTL and testbench
===================================

// Module: ro_puf_sequencer
// PURPOSE
//  Challenge/response controller for the ring-oscillator PUF array.
//  Latches an 8-bit challenge and derives RESP_BITS oscillator pairs from it.
//  For each pair it clears the edge counters, gates the oscillators for a fixed window,
//  lets the counts settle, then compares them into one response bit.
//  Sits between the top-level pins and the oscillator/mux/counter datapath.
// PARAMETERS
//  NUM_RO     8    oscillators per bank; sel width SEL_W = 3 (fixed for 8)
//  CNT_W      8    width of cnt_a/cnt_b from the edge counters
//  WINDOW     256  clk cycles ro_en is held high per bit (>=1)
//  SETTLE_CYC 4    clk cycles after ro_en falls before compare (>=1; covers counter sync)
//  RESP_BITS  8    response bits per challenge (1..16)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          reset, asynchronous, active-high
//  start      in   1          request; sampled only in IDLE
//  challenge  in   8          latched on accepted start
//  cnt_a      in   CNT_W      synchronized count of bank-A selected RO
//  cnt_b      in   CNT_W      synchronized count of bank-B selected RO
//  resp_ready in   1          consumer accepts response
//  sel_a      out  3          bank-A mux select
//  sel_b      out  3          bank-B mux select
//  ro_en      out  1          oscillator/counter enable
//  cnt_clr    out  1          synchronous clear pulse to both counters
//  busy       out  1          high in every state except IDLE
//  response   out  RESP_BITS  response word, bit k = result of pair k
//  resp_valid out  1          response held valid until accepted
//  tie_flag   out  1          sticky: some pair compared equal
//  sat_flag   out  1          sticky: some count reached all-ones
// BEHAVIOUR
//  - Reset (any time, incl. mid-run): state IDLE, all outputs 0, bit index k=0, challenge reg 0.
//  - FSM: IDLE -> CLR -> RUN -> SETTLE -> CMP -> (CLR if k<RESP_BITS-1, else DONE) -> IDLE.
//  - IDLE: start=1 latches challenge into ch, clears response/tie_flag/sat_flag, k=0, -> CLR.
//  - CLR: 1 cycle, cnt_clr=1, ro_en=0.
//  - RUN: exactly WINDOW cycles, ro_en=1.
//  - SETTLE: exactly SETTLE_CYC cycles, ro_en=0.
//  - CMP: 1 cycle; response[k] <= (cnt_a > cnt_b), unsigned strict compare.
//    Tie gives 0 and sets tie_flag; either count == all-ones sets sat_flag.
//  - Pair selection, valid in all non-IDLE states for current k:
//    sel_a = (ch[2:0] + k) mod 8.
//    sel_b = sel_a ^ d, where d = ch[5:3], or 3'b001 if ch[5:3]==0; never equals sel_a.
//    ch[7:6] reserved, ignored.
//  - sel_a/sel_b change only on CMP->CLR edge; stable through CLR/RUN/SETTLE/CMP.
//  - DONE: resp_valid=1; response/flags stable until resp_valid&resp_ready, then -> IDLE.
//    resp_valid falls the cycle after acceptance.
//  - Latency: resp_valid rises RESP_BITS*(WINDOW+SETTLE_CYC+2)+1 cycles after the accepted start edge.
//  - start while busy (incl. DONE, incl. same cycle as resp_ready) is ignored, not queued.
//  - response/flags remain readable in IDLE until the next accepted start.
//  - sel_a/sel_b = 0 in IDLE. ro_en never high outside RUN. cnt_clr never high outside CLR.
// TESTING (WINDOW=4, SETTLE_CYC=2, RESP_BITS=4 unless stated)
//  1. challenge=8'h0A, start 1 cycle, model cnt_a=9,cnt_b=5 all pairs.
//     -> sel_a 2,3,4,5; sel_b 3,2,5,4; response=4'hF; resp_valid at start+33.
//  2. challenge=8'h00, cnt_a==cnt_b=7 -> sel_b=sel_a^1, response=0, tie_flag=1, sat_flag=0.
//  3. cnt_a=8'hFF, cnt_b=3 on pair 2 only, else a<b -> response=4'b0100, sat_flag=1.
//  4. Hold resp_ready=0 for 10 cycles in DONE, pulse start -> response stable, no restart.
//     Then ready=1 -> IDLE next cycle.
//  5. Assert rst_n during RUN of pair 1 -> same cycle ro_en=0, busy=0; next start runs full sequence.
//  6. Check ro_en high exactly WINDOW cycles and cnt_clr exactly 1 cycle per bit, 4 times per run.

Source files
------------

// File: rtl/ro_puf_sequencer.sv
// Challenge/response sequencer for the ring-oscillator PUF: walks RESP_BITS oscillator
// pairs derived from a latched challenge, timing clear/run/settle/compare for each pair.
module ro_puf_sequencer #(
  parameter int NUM_RO     = 8,
  parameter int CNT_W      = 8,
  parameter int WINDOW     = 256,
  parameter int SETTLE_CYC = 4,
  parameter int RESP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           challenge,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  input  logic                 resp_ready,
  output logic [2:0]           sel_a,
  output logic [2:0]           sel_b,
  output logic                 ro_en,
  output logic                 cnt_clr,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  output logic                 tie_flag,
  output logic                 sat_flag
);

  localparam int SEL_W = $clog2(NUM_RO);
  localparam int MAXC  = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W = $clog2(MAXC + 1);
  localparam int K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, CMP, DONE} state_t;

  state_t               state_q, state_d;
  logic [5:0]           ch_q, ch_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic                 tie_q, tie_d;
  logic                 sat_q, sat_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [SEL_W-1:0]     sel_a_c, dist_c;
  logic                 last_pair;

  // ch[7:6] are reserved and deliberately not stored
  logic ch_unused;
  assign ch_unused = &{1'b0, challenge[7:6]};

  assign last_pair = (k_q == K_W'(RESP_BITS - 1));

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (tmr_q == '0) state_d = SETTLE;
      SETTLE:  if (tmr_q == '0) state_d = CMP;
      CMP:     state_d = last_pair ? DONE : CLR;
      DONE:    if (resp_valid_q && resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ch_q         <= '0;
      k_q          <= '0;
      tmr_q        <= '0;
      response_q   <= '0;
      tie_q        <= 1'b0;
      sat_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      k_q          <= k_d;
      tmr_q        <= tmr_d;
      response_q   <= response_d;
      tie_q        <= tie_d;
      sat_q        <= sat_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    ch_d       = ch_q;
    k_d        = k_q;
    tmr_d      = tmr_q;
    response_d = response_q;
    tie_d      = tie_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: if (start) begin
        ch_d       = challenge[5:0];
        k_d        = '0;
        response_d = '0;
        tie_d      = 1'b0;
        sat_d      = 1'b0;
      end
      CLR:    tmr_d = TMR_W'(WINDOW - 1);
      RUN:    tmr_d = (tmr_q == '0) ? TMR_W'(SETTLE_CYC - 1) : tmr_q - 1'b1;
      SETTLE: if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
      CMP: begin
        response_d[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b)                  tie_d = 1'b1;
        if (cnt_a == '1 || cnt_b == '1)      sat_d = 1'b1;
        if (!last_pair)                      k_d   = k_q + 1'b1;
      end
      default: ;
    endcase
    // Registered so the handshake drop lands the cycle after acceptance
    resp_valid_d = (state_q == DONE) && !(resp_valid_q && resp_ready);
  end

  // Output logic; a zero bank distance is forced to 1 so the pair never collapses
  always_comb begin
    sel_a_c = ch_q[2:0] + SEL_W'(k_q);
    dist_c  = (ch_q[5:3] == 3'd0) ? 3'd1 : ch_q[5:3];
    busy    = (state_q != IDLE);
    ro_en   = (state_q == RUN);
    cnt_clr = (state_q == CLR);
    sel_a   = busy ? sel_a_c : 3'd0;
    sel_b   = busy ? (sel_a_c ^ dist_c) : 3'd0;
  end

  assign response   = response_q;
  assign resp_valid = resp_valid_q;
  assign tie_flag   = tie_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer with a small per-pair counter model.
module tb_ro_puf_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] challenge = 8'h00;
  logic [7:0] cnt_a, cnt_b;
  logic       resp_ready = 1'b0;
  logic [2:0] sel_a, sel_b;
  logic       ro_en, cnt_clr, busy, resp_valid, tie_flag, sat_flag;
  logic [3:0] response;

  int vecs = 0;
  int errs = 0;
  int mode = 0;

  ro_puf_sequencer #(.NUM_RO(8), .CNT_W(8), .WINDOW(4), .SETTLE_CYC(2), .RESP_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .resp_ready(resp_ready),
    .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .cnt_clr(cnt_clr), .busy(busy),
    .response(response), .resp_valid(resp_valid), .tie_flag(tie_flag), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Counter model: mode 0 a>b, mode 1 tie, mode 2 saturated win on oscillator 2 only
  always_comb begin
    cnt_a = 8'd9; cnt_b = 8'd5;
    case (mode)
      1: begin cnt_a = 8'd7; cnt_b = 8'd7; end
      2: begin
        cnt_a = (sel_a == 3'd2) ? 8'hFF : 8'd1;
        cnt_b = (sel_a == 3'd2) ? 8'd3  : 8'd5;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one challenge and leaves the DUT sitting in DONE
  task automatic run_seq(input string tag, input logic [7:0] chal, input logic [11:0] exp_sa,
                         input logic [11:0] exp_sb, input logic [3:0] exp_resp,
                         input logic exp_tie, input logic exp_sat);
    int n, nro, nclr, pair, overlap;
    logic [11:0] got_sa, got_sb;
    n = 0; nro = 0; nclr = 0; pair = 0; overlap = 0; got_sa = '0; got_sb = '0;
    @(negedge clk); challenge = chal; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!resp_valid && n < 100) begin
      if (ro_en)   nro++;
      if (ro_en && cnt_clr) overlap++;
      if (cnt_clr) begin
        nclr++;
        if (pair < 4) begin got_sa[3*pair +: 3] = sel_a; got_sb[3*pair +: 3] = sel_b; end
        pair++;
      end
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"},  n,        33);
    check({tag, " ro_en"},    nro,      16);
    check({tag, " cnt_clr"},  nclr,     4);
    check({tag, " overlap"},  overlap,  0);
    check({tag, " sel_a"},    got_sa,   exp_sa);
    check({tag, " sel_b"},    got_sb,   exp_sb);
    check({tag, " response"}, response, exp_resp);
    check({tag, " tie"},      tie_flag, exp_tie);
    check({tag, " sat"},      sat_flag, exp_sat);
    check({tag, " busy"},     busy,     1);
  endtask

  task automatic accept(input string tag);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " rv_drop"},   resp_valid, 0);
    check({tag, " idle"},      busy,       0);
    resp_ready = 1'b0;
  endtask

  initial begin
    // Reset is active-high
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  busy, 0);
    check("rst ro_en", ro_en, 0);
    check("rst clr",   cnt_clr, 0);
    check("rst sel",   {sel_a, sel_b}, 0);
    check("rst resp",  {response, resp_valid, tie_flag, sat_flag}, 0);
    @(negedge clk); rst_n = 1'b0;

    // 1: ch=0A -> sel_a 2,3,4,5 ; sel_b 3,2,5,4
    mode = 0;
    run_seq("t1", 8'h0A, {3'd5, 3'd4, 3'd3, 3'd2}, {3'd4, 3'd5, 3'd2, 3'd3}, 4'hF, 1'b0, 1'b0);
    accept("t1");

    // 2: ch=00 -> distance forced to 1
    mode = 1;
    run_seq("t2", 8'h00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd2, 3'd3, 3'd0, 3'd1}, 4'h0, 1'b1, 1'b0);
    accept("t2");

    // 3: saturated count wins only on pair 2
    mode = 2;
    run_seq("t3", 8'h00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd2, 3'd3, 3'd0, 3'd1}, 4'b0100, 1'b0, 1'b1);

    // 4: hold in DONE, stray start ignored
    repeat (5) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4 hold resp", response, 4'b0100);
    check("t4 hold rv",   resp_valid, 1);
    check("t4 hold busy", busy, 1);
    @(negedge clk); start = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; resp_ready = 1'b0;
    check("t4 acc rv",   resp_valid, 0);
    check("t4 acc busy", busy, 0);
    @(posedge clk); #1;
    check("t4 no queue", busy, 0);
    check("t4 idle resp", {response, sat_flag}, {4'b0100, 1'b1});
    check("t4 idle sel", {sel_a, sel_b}, 0);

    // 5: reset during RUN of pair 1
    mode = 0;
    @(negedge clk); challenge = 8'h0A; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5 in run", {ro_en, sel_a}, {1'b1, 3'd3});
    rst_n = 1'b1; #1;
    check("t5 ro_en", ro_en, 0);
    check("t5 busy",  busy, 0);
    check("t5 sel",   {sel_a, sel_b}, 0);
    check("t5 resp",  {response, tie_flag, sat_flag}, 0);
    @(negedge clk); rst_n = 1'b0;
    run_seq("t5r", 8'h0A, {3'd5, 3'd4, 3'd3, 3'd2}, {3'd4, 3'd5, 3'd2, 3'd3}, 4'hF, 1'b0, 1'b0);
    accept("t5r");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
